// File: rtl/chacha_xor.sv
// chacha_xor: keystream consumer sitting directly behind the chacha core.
// It pulls one 64-byte keystream block from the core into a local buffer.
// It then XORs that buffer byte-by-byte onto a valid/ready plaintext
// stream, which gives a valid/ready ciphertext stream. When the buffer
// runs out it fetches the next block. The cipher is symmetric, so the
// same path also decrypts.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset (also resets the core)
//   blk_ready  core has a keystream block available
//   rd_blk     one-cycle pulse that starts a core block read
//   ks_in      keystream byte from the core (byte k arrives k+1 cycles after rd_blk)
//   pt_data    plaintext byte
//   pt_valid   plaintext byte valid
//   pt_ready   plaintext byte accepted this cycle
//   ct_data    ciphertext byte (registered)
//   ct_valid   ciphertext byte valid
//   ct_ready   sink accepts ciphertext
//   flush      one-cycle pulse that discards the rest of the current block
//   blk_cnt    blocks fetched since reset (wraps at 16 bits)
//
// BLK_BYTES must stay at 64: the buffer pointers are 6 bits wide.
//
// state | meaning
// IDLE  | wait for blk_ready, then pulse rd_blk
// FETCH | capture 64 keystream bytes from the core, one per cycle
// SERVE | XOR plaintext against the buffered keystream

module chacha_xor #(
  parameter int BLK_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        blk_ready,
  output logic        rd_blk,
  input  logic [7:0]  ks_in,
  input  logic [7:0]  pt_data,
  input  logic        pt_valid,
  output logic        pt_ready,
  output logic [7:0]  ct_data,
  output logic        ct_valid,
  input  logic        ct_ready,
  input  logic        flush,
  output logic [15:0] blk_cnt
);

  localparam logic [5:0] LAST_IDX = 6'(BLK_BYTES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SERVE} state_t;

  state_t     state, state_nxt;
  logic [7:0] ks_buf [BLK_BYTES];
  logic [5:0] wr_ptr, rd_ptr;
  logic       flush_pend;
  logic       pt_hs;
  logic       last_wr;

  assign pt_hs   = pt_valid && pt_ready;
  assign last_wr = (wr_ptr == LAST_IDX);

  // rd_blk and pt_ready are decoded from state. They are gated by rst_n so
  // that both read 0 while reset is held, even when blk_ready is high.
  always_comb begin
    state_nxt = state;
    rd_blk    = 1'b0;
    pt_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (blk_ready) begin
          rd_blk    = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        // A flush during the fetch only takes effect once the whole block
        // has been read. This keeps the core's stream in step with us.
        if (last_wr) begin
          state_nxt = (flush_pend || flush) ? IDLE : SERVE;
        end
      end
      SERVE: begin
        pt_ready = !ct_valid || ct_ready;
        if (flush || (pt_valid && pt_ready && rd_ptr == LAST_IDX)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) begin
      rd_blk   = 1'b0;
      pt_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      flush_pend <= 1'b0;
      blk_cnt    <= '0;
      ct_valid   <= 1'b0;
      ct_data    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          wr_ptr <= '0;
        end
        FETCH: begin
          wr_ptr <= wr_ptr + 6'd1;
          if (flush) begin
            flush_pend <= 1'b1;
          end
          if (last_wr) begin
            blk_cnt    <= blk_cnt + 16'd1;
            rd_ptr     <= '0;
            flush_pend <= 1'b0;
          end
        end
        SERVE: begin
          if (pt_hs) begin
            rd_ptr <= rd_ptr + 6'd1;
          end
        end
        default: ;
      endcase

      // The output register drains in every state. A pending byte therefore
      // survives the move from SERVE back to IDLE or FETCH.
      if (pt_hs) begin
        ct_data  <= pt_data ^ ks_buf[rd_ptr];
        ct_valid <= 1'b1;
      end else if (ct_ready) begin
        ct_valid <= 1'b0;
      end
    end
  end

  // Keystream buffer has no reset: its contents are only read after a
  // complete fetch has overwritten them.
  always_ff @(posedge clk) begin
    if (state == FETCH) begin
      ks_buf[wr_ptr] <= ks_in;
    end
  end

endmodule
